// File: rtl/gpu_tile_pkg.sv
// Shared types and constants for the 8x8 tile pipeline.
package gpu_tile_pkg;

    localparam int TILE_DIM    = 8;
    localparam int TILE_ADDR_W = 6;
    localparam int PIX_W       = 24;
    localparam int TCOL_W      = 7;
    localparam int TROW_W      = 6;
    localparam int SX_W        = TCOL_W + 3;
    localparam int SY_W        = TROW_W + 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } scan_state_e;

    // One pixel travelling from the tile read port to the output.
    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic [SX_W-1:0]  x;
        logic [SY_W-1:0]  y;
        logic             last;
    } px_beat_t;

endpackage

// File: rtl/tile_skid_fifo.sv
// Two-entry FIFO of pixel beats; absorbs downstream backpressure behind
// the one-cycle tile read latency.
module tile_skid_fifo
    import gpu_tile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  px_beat_t   i_din,
    output logic [1:0] o_cnt,
    output px_beat_t   o_head
);

    px_beat_t   r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_cnt;

    // Storage, pointers and occupancy; push and pop in one cycle keep the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            unique case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_cnt  = r_cnt;
    assign o_head = r_mem[r_rd_ptr];

    // The issue rule upstream must keep these from ever firing.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(i_push && !i_pop && r_cnt == 2'd2));
    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        !(i_pop && r_cnt == 2'd0));

endmodule

// File: rtl/tile_scanout.sv
// Drains an 8x8 tile buffer in raster order and streams the pixels out on
// a valid/ready handshake with absolute screen coordinates attached.
module tile_scanout #(
    parameter int PIX_W  = gpu_tile_pkg::PIX_W,
    parameter int TCOL_W = gpu_tile_pkg::TCOL_W,
    parameter int TROW_W = gpu_tile_pkg::TROW_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TCOL_W-1:0] tile_col,
    input  logic [TROW_W-1:0] tile_row,
    output logic              busy,
    output logic              done,
    output logic [2:0]        rd_y,
    output logic [2:0]        rd_x,
    output logic              rd_en,
    output logic              rd_active,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              px_valid,
    input  logic              px_ready,
    output logic [PIX_W-1:0]  px_data,
    output logic [TCOL_W+2:0] px_x,
    output logic [TROW_W+2:0] px_y,
    output logic              px_last
);

    import gpu_tile_pkg::*;

    scan_state_e            r_state;
    logic [TILE_ADDR_W-1:0] r_addr;
    logic                   r_inflight;
    logic [TCOL_W-1:0]      r_tcol;
    logic [TROW_W-1:0]      r_trow;
    logic [TCOL_W+2:0]      r_pend_x;
    logic [TROW_W+2:0]      r_pend_y;
    logic                   r_pend_last;

    logic [1:0]             w_fifo_cnt;
    px_beat_t               w_head;
    px_beat_t               w_push_beat;
    logic                   w_pop;
    logic                   w_rd_issue;
    logic                   w_done;
    logic [2:0]             w_occ;

    // Read issue: occupancy after this cycle (queued + in flight - leaving) stays <= 2.
    always_comb begin
        w_pop      = (w_fifo_cnt != 2'd0) && px_ready;
        w_occ      = {1'b0, w_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_rd_issue = (r_state == RUN) && (w_occ < 3'd2);
        w_done     = (r_state == DRAIN) && (w_fifo_cnt == 2'd0) && !r_inflight;
    end

    // Beat pushed when last cycle's read returns; coords ride alongside the read.
    always_comb begin
        w_push_beat      = '0;
        w_push_beat.data = rd_data;
        w_push_beat.x    = r_pend_x;
        w_push_beat.y    = r_pend_y;
        w_push_beat.last = r_pend_last;
    end

    // Scan FSM, address counter and in-flight read tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_inflight  <= 1'b0;
            r_tcol      <= '0;
            r_trow      <= '0;
            r_pend_x    <= '0;
            r_pend_y    <= '0;
            r_pend_last <= 1'b0;
        end else begin
            r_inflight <= w_rd_issue;
            if (w_rd_issue) begin
                r_pend_x    <= {r_tcol, r_addr[2:0]};
                r_pend_y    <= {r_trow, r_addr[5:3]};
                r_pend_last <= (r_addr == '1);
            end
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_tcol  <= tile_col;
                        r_trow  <= tile_row;
                        r_addr  <= '0;
                    end
                end
                RUN: begin
                    if (w_rd_issue) begin
                        r_addr <= r_addr + TILE_ADDR_W'(1);
                        if (r_addr == '1) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The done cycle also accepts a new start.
                    if (w_done) begin
                        if (start) begin
                            r_state <= RUN;
                            r_tcol  <= tile_col;
                            r_trow  <= tile_row;
                            r_addr  <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    tile_skid_fifo u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (r_inflight),
        .i_pop  (w_pop),
        .i_din  (w_push_beat),
        .o_cnt  (w_fifo_cnt),
        .o_head (w_head)
    );

    assign busy      = (r_state != IDLE);
    assign rd_active = busy;
    assign done      = w_done;
    assign rd_en     = w_rd_issue;
    assign rd_y      = r_addr[5:3];
    assign rd_x      = r_addr[2:0];
    assign px_valid  = (w_fifo_cnt != 2'd0);
    assign px_data   = w_head.data;
    assign px_x      = w_head.x;
    assign px_y      = w_head.y;
    assign px_last   = w_head.last;

endmodule
